leap_ctrl: RTL and testbench

- Pipeline stall and leap sequencer for the 5-stage RV32I core; sits beside the hazard/forwarding logic.
- On a D-cache miss in MA it freezes the pipe, then consumes the leapfrog permission signal (leap_ok). Independent EX instructions may bypass the stalled MA stage straight into WB, up to LEAP_MAX per miss.
- Sequences the stage stall enables, the WB source select and the resume cycle.
- Also covers I-cache miss stalls while running normally.

---
 rtl/leap_ctrl_pkg.sv | 22 ++
 rtl/leap_ctrl_if.sv | 46 ++++
 rtl/leap_ctrl_sat_counter.sv | 24 ++
 rtl/leap_ctrl.sv | 137 +++++++++++++
 tb/tb_leap_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leap_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall / leap sequencer.
package leap_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MISS   = 2'd1,
        FULL   = 2'd2,
        RESUME = 2'd3
    } leap_state_t;

    localparam int unsigned LEAP_MAX_DEFAULT = 4;
    localparam int unsigned PERF_W_DEFAULT   = 32;

    // WAW guard: a leaped EX result must not be overwritten by the older load
    // still pending in MA. x0 is never a real destination.
    function automatic logic waw_hazard(input logic       wr,
                                        input logic [4:0] ex_rd,
                                        input logic [4:0] ma_rd);
        return wr && (ex_rd != 5'd0) && (ex_rd == ma_rd);
    endfunction

endpackage

// File: rtl/leap_ctrl_if.sv
// Pipeline-side signal bundle between the core datapath and leap_ctrl.
interface leap_ctrl_if
    import leap_ctrl_pkg::*;
#(
    parameter int unsigned LEAP_MAX = LEAP_MAX_DEFAULT,
    parameter int unsigned PERF_W   = PERF_W_DEFAULT
);
    localparam int unsigned LC_W = $clog2(LEAP_MAX + 1);

    // Pipeline status into the sequencer
    logic            imem_resp;
    logic            dmem_req;
    logic            dmem_resp;
    logic            leap_ok;
    logic            ex_valid;
    logic            ex_is_ctrl;
    logic            ex_writes_rd;
    logic [4:0]      ex_rd;
    logic [4:0]      ma_rd;

    // Sequencer controls back to the pipeline
    logic            stall_if;
    logic            stall_id;
    logic            stall_ex;
    logic            stall_ma;
    logic            bubble_wb;
    logic            leap_fire;
    logic            wb_leap;
    logic [LC_W-1:0] leap_cnt;
    logic [PERF_W-1:0] perf_leaps;

    modport master (
        output imem_resp, dmem_req, dmem_resp, leap_ok, ex_valid,
               ex_is_ctrl, ex_writes_rd, ex_rd, ma_rd,
        input  stall_if, stall_id, stall_ex, stall_ma, bubble_wb,
               leap_fire, wb_leap, leap_cnt, perf_leaps
    );

    modport slave (
        input  imem_resp, dmem_req, dmem_resp, leap_ok, ex_valid,
               ex_is_ctrl, ex_writes_rd, ex_rd, ma_rd,
        output stall_if, stall_id, stall_ex, stall_ma, bubble_wb,
               leap_fire, wb_leap, leap_cnt, perf_leaps
    );

endinterface

// File: rtl/leap_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count enabled events, sticking at the maximum value
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/leap_ctrl.sv
// Stall and leapfrog sequencer: freezes the pipe on a D-cache miss and lets
// independent EX instructions bypass the stalled MA stage into WB.
module leap_ctrl
    import leap_ctrl_pkg::*;
#(
    parameter int unsigned LEAP_MAX = LEAP_MAX_DEFAULT,
    parameter int unsigned PERF_W   = PERF_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    leap_ctrl_if.slave  bus
);

    localparam int unsigned LC_W = $clog2(LEAP_MAX + 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LEAP_MAX - 1);

    leap_state_t     r_state;
    leap_state_t     w_next_state;
    logic [LC_W-1:0] r_leap_cnt;
    logic            r_wb_leap;
    logic            w_can_leap;
    logic            w_leap_fire;
    logic            w_stall_front;
    logic            w_stall_ma;
    logic            w_bubble_wb;
    logic [PERF_W-1:0] w_perf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and stall/bubble/leap decode; dmem_resp always beats a leap
    always_comb begin
        w_next_state  = r_state;
        w_stall_front = 1'b0;
        w_stall_ma    = 1'b0;
        w_bubble_wb   = 1'b0;
        w_leap_fire   = 1'b0;
        w_can_leap    = bus.ex_valid && bus.leap_ok && !bus.ex_is_ctrl &&
                        bus.imem_resp && !bus.dmem_resp &&
                        !waw_hazard(bus.ex_writes_rd, bus.ex_rd, bus.ma_rd);
        case (r_state)
            RUN: begin
                if (bus.dmem_req && !bus.dmem_resp) begin
                    w_stall_front = 1'b1;
                    w_stall_ma    = 1'b1;
                    w_bubble_wb   = 1'b1;
                    w_next_state  = MISS;
                end else if (!bus.imem_resp) begin
                    w_stall_front = 1'b1;
                    w_stall_ma    = 1'b1;
                end
            end
            MISS: begin
                if (bus.dmem_resp) begin
                    w_stall_front = 1'b1;
                    w_next_state  = RESUME;
                end else if (w_can_leap) begin
                    w_stall_ma  = 1'b1;
                    w_leap_fire = 1'b1;
                    if (r_leap_cnt == LC_LAST) begin
                        w_next_state = FULL;
                    end
                end else begin
                    w_stall_front = 1'b1;
                    w_stall_ma    = 1'b1;
                    w_bubble_wb   = 1'b1;
                end
            end
            FULL: begin
                if (bus.dmem_resp) begin
                    w_stall_front = 1'b1;
                    w_next_state  = RESUME;
                end else begin
                    w_stall_front = 1'b1;
                    w_stall_ma    = 1'b1;
                    w_bubble_wb   = 1'b1;
                end
            end
            RESUME: begin
                // MA only holds a fresh instruction after this edge, so a
                // request seen now is not yet treated as a miss.
                if (!bus.imem_resp) begin
                    w_stall_front = 1'b1;
                    w_stall_ma    = 1'b1;
                end
                w_next_state = RUN;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    // Per-miss leap count, cleared as the pipe resumes
    always_ff @(posedge clk) begin
        if (rst || (r_state == RESUME)) begin
            r_leap_cnt <= '0;
        end else if (w_leap_fire) begin
            r_leap_cnt <= r_leap_cnt + LC_W'(1);
        end
    end

    // Flag that WB holds a leaped instruction this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_leap <= 1'b0;
        end else begin
            r_wb_leap <= w_leap_fire;
        end
    end

    sat_counter #(
        .W (PERF_W)
    ) u_perf (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_leap_fire),
        .o_count (w_perf)
    );

    assign bus.stall_if   = w_stall_front;
    assign bus.stall_id   = w_stall_front;
    assign bus.stall_ex   = w_stall_front;
    assign bus.stall_ma   = w_stall_ma;
    assign bus.bubble_wb  = w_bubble_wb;
    assign bus.leap_fire  = w_leap_fire;
    assign bus.wb_leap    = r_wb_leap;
    assign bus.leap_cnt   = r_leap_cnt;
    assign bus.perf_leaps = w_perf;

endmodule

// File: tb/tb_leap_ctrl.sv
// Directed bench for leap_ctrl: hit, miss, leap limit, guards, collision, reset, I-cache stall.
module tb_leap_ctrl;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    leap_ctrl_if #(.LEAP_MAX(4), .PERF_W(32)) bus ();

    leap_ctrl #(.LEAP_MAX(4), .PERF_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_if, stall_id, stall_ex, stall_ma, bubble_wb, leap_fire}
    logic [5:0] obs;
    assign obs = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_ma,
                  bus.bubble_wb, bus.leap_fire};

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_FREEZE = 6'b111110;
    localparam logic [5:0] C_LEAP  = 6'b000101;
    localparam logic [5:0] C_RESP  = 6'b111000;
    localparam logic [5:0] C_ISTALL = 6'b111100;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_resp    = 1'b1;
        bus.dmem_req     = 1'b0;
        bus.dmem_resp    = 1'b0;
        bus.leap_ok      = 1'b0;
        bus.ex_valid     = 1'b0;
        bus.ex_is_ctrl   = 1'b0;
        bus.ex_writes_rd = 1'b0;
        bus.ex_rd        = 5'd0;
        bus.ma_rd        = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        settle();
        n_total++;
        if (obs !== C_IDLE) $display("FAIL reset_ctrl got=%b exp=%b", obs, C_IDLE);
        else n_pass++;
        n_total++;
        if (bus.leap_cnt !== 3'd0) $display("FAIL reset_cnt got=%0d exp=0", bus.leap_cnt);
        else n_pass++;
        n_total++;
        if (bus.perf_leaps !== 32'd0) $display("FAIL reset_perf got=%0d exp=0", bus.perf_leaps);
        else n_pass++;
        n_total++;
        if (bus.wb_leap !== 1'b0) $display("FAIL reset_wbleap got=%b exp=0", bus.wb_leap);
        else n_pass++;
    endtask

    task automatic test_hit();
        bus.dmem_req  = 1'b1;
        bus.dmem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_total++;
            if (obs !== C_IDLE) $display("FAIL hit_ctrl[%0d] got=%b exp=%b", i, obs, C_IDLE);
            else n_pass++;
            step();
        end
        idle_inputs();
        settle();
        n_total++;
        if (obs !== C_IDLE) $display("FAIL hit_after got=%b exp=%b", obs, C_IDLE);
        else n_pass++;
        n_total++;
        if (bus.leap_cnt !== 3'd0) $display("FAIL hit_cnt got=%0d exp=0", bus.leap_cnt);
        else n_pass++;
        step();
    endtask

    task automatic test_miss_no_leap();
        bus.dmem_req  = 1'b1;
        bus.dmem_resp = 1'b0;
        bus.ex_valid  = 1'b1;
        bus.leap_ok   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_total++;
            if (obs !== C_FREEZE) $display("FAIL miss_ctrl[%0d] got=%b exp=%b", i, obs, C_FREEZE);
            else n_pass++;
            step();
        end
        bus.dmem_resp = 1'b1;
        settle();
        n_total++;
        if (obs !== C_RESP) $display("FAIL miss_resp got=%b exp=%b", obs, C_RESP);
        else n_pass++;
        step();
        // RESUME: a new request here must not start a miss yet
        bus.dmem_resp = 1'b0;
        settle();
        n_total++;
        if (obs !== C_IDLE) $display("FAIL miss_resume got=%b exp=%b", obs, C_IDLE);
        else n_pass++;
        step();
        settle();
        n_total++;
        if (obs !== C_FREEZE) $display("FAIL miss_rearm got=%b exp=%b", obs, C_FREEZE);
        else n_pass++;
        step();
        bus.dmem_resp = 1'b1;
        settle();
        n_total++;
        if (obs !== C_RESP) $display("FAIL miss_resp2 got=%b exp=%b", obs, C_RESP);
        else n_pass++;
        step();
        idle_inputs();
        step();
        n_total++;
        if (bus.perf_leaps !== 32'd0) $display("FAIL miss_perf got=%0d exp=0", bus.perf_leaps);
        else n_pass++;
    endtask

    task automatic test_leap_limit();
        bus.dmem_req     = 1'b1;
        bus.dmem_resp    = 1'b0;
        bus.ex_valid     = 1'b1;
        bus.leap_ok      = 1'b1;
        bus.ex_writes_rd = 1'b1;
        bus.ex_rd        = 5'd7;
        bus.ma_rd        = 5'd5;
        settle();
        n_total++;
        if (obs !== C_FREEZE) $display("FAIL leap_start got=%b exp=%b", obs, C_FREEZE);
        else n_pass++;
        step();
        for (int c = 1; c < 10; c++) begin
            settle();
            n_total++;
            if (c <= 4) begin
                if (obs !== C_LEAP) $display("FAIL leap_fire[%0d] got=%b exp=%b", c, obs, C_LEAP);
                else n_pass++;
            end else begin
                if (obs !== C_FREEZE) $display("FAIL leap_full[%0d] got=%b exp=%b", c, obs, C_FREEZE);
                else n_pass++;
            end
            n_total++;
            if (bus.wb_leap !== ((c >= 2) && (c <= 5)))
                $display("FAIL leap_wb[%0d] got=%b exp=%b", c, bus.wb_leap, ((c >= 2) && (c <= 5)));
            else n_pass++;
            n_total++;
            if (bus.leap_cnt !== ((c <= 4) ? 3'(c - 1) : 3'd4))
                $display("FAIL leap_cnt[%0d] got=%0d exp=%0d", c, bus.leap_cnt, ((c <= 4) ? (c - 1) : 4));
            else n_pass++;
            step();
        end
        n_total++;
        if (bus.perf_leaps !== 32'd4) $display("FAIL leap_perf got=%0d exp=4", bus.perf_leaps);
        else n_pass++;
        bus.dmem_resp = 1'b1;
        settle();
        n_total++;
        if (obs !== C_RESP) $display("FAIL leap_resp got=%b exp=%b", obs, C_RESP);
        else n_pass++;
        step();
        idle_inputs();
        settle();
        n_total++;
        if (bus.leap_cnt !== 3'd4) $display("FAIL leap_cnt_resume got=%0d exp=4", bus.leap_cnt);
        else n_pass++;
        step();
        n_total++;
        if (bus.leap_cnt !== 3'd0) $display("FAIL leap_cnt_clear got=%0d exp=0", bus.leap_cnt);
        else n_pass++;
        n_total++;
        if (bus.perf_leaps !== 32'd4) $display("FAIL leap_perf_hold got=%0d exp=4", bus.perf_leaps);
        else n_pass++;
    endtask

    task automatic test_guards();
        bus.dmem_req     = 1'b1;
        bus.dmem_resp    = 1'b0;
        bus.ex_valid     = 1'b1;
        bus.leap_ok      = 1'b1;
        bus.ex_writes_rd = 1'b1;
        bus.ex_rd        = 5'd9;
        bus.ma_rd        = 5'd9;
        settle();
        step();
        settle();
        n_total++;
        if (obs !== C_FREEZE) $display("FAIL guard_waw got=%b exp=%b", obs, C_FREEZE);
        else n_pass++;
        bus.ex_is_ctrl = 1'b1;
        bus.ex_rd      = 5'd7;
        settle();
        n_total++;
        if (obs !== C_FREEZE) $display("FAIL guard_ctrl got=%b exp=%b", obs, C_FREEZE);
        else n_pass++;
        bus.ex_is_ctrl = 1'b0;
        bus.imem_resp  = 1'b0;
        settle();
        n_total++;
        if (obs !== C_FREEZE) $display("FAIL guard_imem got=%b exp=%b", obs, C_FREEZE);
        else n_pass++;
        bus.imem_resp = 1'b1;
        bus.ex_rd     = 5'd0;
        bus.ma_rd     = 5'd0;
        settle();
        n_total++;
        if (obs !== C_LEAP) $display("FAIL guard_x0 got=%b exp=%b", obs, C_LEAP);
        else n_pass++;
        step();
        n_total++;
        if (bus.leap_cnt !== 3'd1) $display("FAIL guard_cnt got=%0d exp=1", bus.leap_cnt);
        else n_pass++;
        // Leap conditions still true, but the fill response wins
        bus.dmem_resp = 1'b1;
        settle();
        n_total++;
        if (obs !== C_RESP) $display("FAIL collide got=%b exp=%b", obs, C_RESP);
        else n_pass++;
        step();
        idle_inputs();
        bus.imem_resp = 1'b0;
        settle();
        // RESUME follows RUN stall rules; wb_leap is low since no fire on collision
        n_total++;
        if (obs !== C_ISTALL) $display("FAIL collide_resume got=%b exp=%b", obs, C_ISTALL);
        else n_pass++;
        n_total++;
        if (bus.wb_leap !== 1'b0) $display("FAIL collide_wb got=%b exp=0", bus.wb_leap);
        else n_pass++;
        bus.imem_resp = 1'b1;
        step();
        n_total++;
        if (bus.perf_leaps !== 32'd5) $display("FAIL guard_perf got=%0d exp=5", bus.perf_leaps);
        else n_pass++;
    endtask

    task automatic test_reset_mid_miss();
        bus.dmem_req     = 1'b1;
        bus.dmem_resp    = 1'b0;
        bus.ex_valid     = 1'b1;
        bus.leap_ok      = 1'b1;
        bus.ex_writes_rd = 1'b1;
        bus.ex_rd        = 5'd3;
        bus.ma_rd        = 5'd4;
        for (int i = 0; i < 5; i++) step();
        settle();
        n_total++;
        if (bus.leap_cnt !== 3'd4) $display("FAIL rstmid_pre_cnt got=%0d exp=4", bus.leap_cnt);
        else n_pass++;
        n_total++;
        if (obs !== C_FREEZE) $display("FAIL rstmid_pre_full got=%b exp=%b", obs, C_FREEZE);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        settle();
        n_total++;
        if (obs !== C_IDLE) $display("FAIL rstmid_ctrl got=%b exp=%b", obs, C_IDLE);
        else n_pass++;
        n_total++;
        if (bus.leap_cnt !== 3'd0) $display("FAIL rstmid_cnt got=%0d exp=0", bus.leap_cnt);
        else n_pass++;
        n_total++;
        if (bus.perf_leaps !== 32'd0) $display("FAIL rstmid_perf got=%0d exp=0", bus.perf_leaps);
        else n_pass++;
        n_total++;
        if (bus.wb_leap !== 1'b0) $display("FAIL rstmid_wb got=%b exp=0", bus.wb_leap);
        else n_pass++;
        step();
    endtask

    task automatic test_icache_stall();
        bus.imem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_total++;
            if (obs !== C_ISTALL) $display("FAIL istall[%0d] got=%b exp=%b", i, obs, C_ISTALL);
            else n_pass++;
            step();
        end
        bus.imem_resp = 1'b1;
        settle();
        n_total++;
        if (obs !== C_IDLE) $display("FAIL istall_release got=%b exp=%b", obs, C_IDLE);
        else n_pass++;
        step();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        idle_inputs();
        test_reset();
        test_hit();
        test_miss_no_leap();
        test_leap_limit();
        test_guards();
        test_reset_mid_miss();
        test_icache_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
